// File: rtl/ins_fetch_queue_pkg.sv
// Shared types and helpers for the instruction fetch stage and its queue.
package ins_fetch_queue_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] INST_BYTES = 32'd4;

    // Fetch FSM encodings
    typedef enum logic [1:0] {
        IF_IDLE     = 2'd0,
        IF_WAIT_MEM = 2'd1,
        IF_DISCARD  = 2'd2
    } if_state_e;

    // One queue slot: the instruction word together with the PC it was fetched from
    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } iq_entry_t;

    // Sequential fetch address; 32-bit wrap is intentional
    function automatic logic [DATA_WIDTH-1:0] next_pc(input logic [DATA_WIDTH-1:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/ins_fetch_queue_inst_fifo.sv
// Circular buffer of {pc, inst} entries with push, pop and whole-queue flush.
// Every update is qualified by en so a global stall freezes the queue.
module ins_fetch_queue_inst_fifo
    import ins_fetch_queue_pkg::*;
#(
    parameter int DEPTH_LOG = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      flush,
    input  logic      push,
    input  iq_entry_t push_entry,
    input  logic      pop,
    output logic      out_valid,
    output iq_entry_t head_entry,
    output logic      full
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [DEPTH_LOG-1:0] head_q, head_d;
    logic [DEPTH_LOG-1:0] tail_q, tail_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    iq_entry_t            mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full      = (count_q == (DEPTH_LOG + 1)'(DEPTH));
    assign out_valid = (count_q != '0);

    // Full is evaluated on the pre-pop count, so a same-cycle pop never frees a slot for a push
    assign do_push = en && push && !flush && !full;
    assign do_pop  = en && pop && !flush && out_valid;

    // Head is forced to zero while empty so the read port never exposes stale slots
    assign head_entry = out_valid ? mem_q[head_q] : '0;

    // Pointer and occupancy next-state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (en && flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + DEPTH_LOG'(1);
            if (do_pop)  head_d = head_q + DEPTH_LOG'(1);
            if (do_push && !do_pop)      count_d = count_q + (DEPTH_LOG + 1)'(1);
            else if (do_pop && !do_push) count_d = count_q - (DEPTH_LOG + 1)'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observable once counted as valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= push_entry;
    end

endmodule

// File: rtl/ins_fetch_queue.sv
// Instruction fetch stage: probes the ICache at pc, refills it from memory on a miss,
// and buffers fetched {pc, inst} pairs for the decoder. Redirects flush and restart fetch.
module ins_fetch_queue
    import ins_fetch_queue_pkg::*;
#(
    parameter int          IQ_DEPTH_LOG = 4,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic [31:0] icache_addr,
    input  logic        icache_hit,
    input  logic [31:0] icache_inst,
    output logic        icache_we,
    output logic [31:0] icache_waddr,
    output logic [31:0] icache_wdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_inst,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        jump_flag,
    input  logic [31:0] jump_pc
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        icache_we_q, icache_we_d;
    logic [31:0] icache_waddr_q, icache_waddr_d;
    logic [31:0] icache_wdata_q, icache_wdata_d;

    logic      q_push;
    iq_entry_t q_entry;
    logic      q_full;
    logic      q_valid;
    iq_entry_t q_head;

    ins_fetch_queue_inst_fifo #(
        .DEPTH_LOG (IQ_DEPTH_LOG)
    ) u_inst_fifo (
        .clk        (clk),
        .rst        (rst),
        .en         (rdy),
        .flush      (jump_flag),
        .push       (q_push),
        .push_entry (q_entry),
        .pop        (out_ready),
        .out_valid  (q_valid),
        .head_entry (q_head),
        .full       (q_full)
    );

    assign icache_addr  = pc_q;
    assign icache_we    = icache_we_q;
    assign icache_waddr = icache_waddr_q;
    assign icache_wdata = icache_wdata_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign out_valid    = q_valid;
    assign out_inst     = q_head.inst;
    assign out_pc       = q_head.pc;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IF_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: a redirect mid-miss waits out the outstanding response in DISCARD
    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                IF_IDLE: begin
                    if (!jump_flag && !q_full && !icache_hit) state_d = IF_WAIT_MEM;
                end
                IF_WAIT_MEM: begin
                    if (mem_done)       state_d = IF_IDLE;
                    else if (jump_flag) state_d = IF_DISCARD;
                end
                IF_DISCARD: begin
                    if (mem_done) state_d = IF_IDLE;
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

    // FSM outputs: queue push, memory request, ICache fill and pc update
    always_comb begin
        pc_d           = pc_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        icache_we_d    = 1'b0;
        icache_waddr_d = icache_waddr_q;
        icache_wdata_d = icache_wdata_q;
        q_push         = 1'b0;
        q_entry        = '{pc: pc_q, inst: icache_inst};
        if (rdy) begin
            case (state_q)
                IF_IDLE: begin
                    if (!jump_flag && !q_full) begin
                        if (icache_hit) begin
                            q_push = 1'b1;
                            pc_d   = next_pc(pc_q);
                        end else begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = pc_q;
                        end
                    end
                end
                IF_WAIT_MEM, IF_DISCARD: begin
                    if (mem_done) begin
                        // The returned word is correct for mem_addr even after a redirect, so always fill
                        mem_req_d      = 1'b0;
                        icache_we_d    = 1'b1;
                        icache_waddr_d = mem_addr_q;
                        icache_wdata_d = mem_inst;
                        if (state_q == IF_WAIT_MEM && !jump_flag) begin
                            q_push  = 1'b1;
                            q_entry = '{pc: mem_addr_q, inst: mem_inst};
                            pc_d    = next_pc(mem_addr_q);
                        end
                    end
                end
                default: ;
            endcase
            if (jump_flag) pc_d = jump_pc;
        end
    end

    // Datapath registers; icache_we clears even when stalled so a fill is never repeated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            icache_we_q    <= 1'b0;
            icache_waddr_q <= '0;
            icache_wdata_q <= '0;
        end else begin
            pc_q           <= pc_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            icache_we_q    <= icache_we_d;
            icache_waddr_q <= icache_waddr_d;
            icache_wdata_q <= icache_wdata_d;
        end
    end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue. The ICache model hits everywhere except at miss_addr
// (when miss_en is set) and returns addr ^ 32'hDEAD0000 as the instruction.
module tb_ins_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] icache_addr;
    logic        icache_hit;
    logic [31:0] icache_inst;
    logic        icache_we;
    logic [31:0] icache_waddr;
    logic [31:0] icache_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done = 1'b0;
    logic [31:0] mem_inst = '0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_pc = '0;

    logic        miss_en = 1'b0;
    logic [31:0] miss_addr = '0;

    int n_tests = 0;
    int n_fail  = 0;

    assign icache_hit  = !(miss_en && (icache_addr == miss_addr));
    assign icache_inst = icache_addr ^ 32'hDEAD_0000;

    ins_fetch_queue #(
        .IQ_DEPTH_LOG (4),
        .RESET_PC     (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .icache_addr  (icache_addr),
        .icache_hit   (icache_hit),
        .icache_inst  (icache_inst),
        .icache_we    (icache_we),
        .icache_waddr (icache_waddr),
        .icache_wdata (icache_wdata),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_done     (mem_done),
        .mem_inst     (mem_inst),
        .out_valid    (out_valid),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_ready    (out_ready),
        .jump_flag    (jump_flag),
        .jump_pc      (jump_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; mem_done = 1'b0; mem_inst = '0; out_ready = 1'b0;
        jump_flag = 1'b0; jump_pc = '0; miss_en = 1'b0; miss_addr = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin step(); n++; end
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL %s_mem_req_timeout: got %b want 1", tag, mem_req); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0)      begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_tests++; if (mem_req !== 1'b0)        begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_tests++; if (icache_we !== 1'b0)      begin n_fail++; $display("FAIL rst_icache_we: got %b want 0", icache_we); end
        n_tests++; if (icache_addr !== 32'h0)   begin n_fail++; $display("FAIL rst_pc: got %h want 0", icache_addr); end
        n_tests++; if (out_pc !== 32'h0)        begin n_fail++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
        n_tests++; if (out_inst !== 32'h0)      begin n_fail++; $display("FAIL rst_out_inst: got %h want 0", out_inst); end
        n_tests++; if (mem_addr !== 32'h0)      begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_tests++; if (icache_waddr !== 32'h0)  begin n_fail++; $display("FAIL rst_waddr: got %h want 0", icache_waddr); end
        n_tests++; if (icache_wdata !== 32'h0)  begin n_fail++; $display("FAIL rst_wdata: got %h want 0", icache_wdata); end
    endtask

    task automatic test_hit_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hit_valid[%0d]: got %b want 1", i, out_valid); end
            n_tests++; if (out_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL hit_pc[%0d]: got %h want %h", i, out_pc, 32'(4 * i)); end
            n_tests++; if (out_inst !== (32'(4 * i) ^ 32'hDEAD_0000)) begin n_fail++; $display("FAIL hit_inst[%0d]: got %h", i, out_inst); end
            n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hit_mem_req[%0d]: got %b want 0", i, mem_req); end
        end
    endtask

    task automatic test_miss();
        do_reset();
        miss_en = 1'b1; miss_addr = 32'h10; out_ready = 1'b1;
        wait_mem_req("miss");
        n_tests++; if (mem_addr !== 32'h10)    begin n_fail++; $display("FAIL miss_mem_addr: got %h want 10", mem_addr); end
        n_tests++; if (icache_addr !== 32'h10) begin n_fail++; $display("FAIL miss_pc_hold: got %h want 10", icache_addr); end
        n_tests++; if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL miss_drained: got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++; if (mem_req !== 1'b1 || icache_we !== 1'b0 || out_valid !== 1'b0)
                begin n_fail++; $display("FAIL miss_wait[%0d]: req=%b we=%b valid=%b want 1 0 0", i, mem_req, icache_we, out_valid); end
        end
        mem_done = 1'b1; mem_inst = 32'h0050_0093;
        step();
        mem_done = 1'b0; mem_inst = '0;
        n_tests++; if (icache_we !== 1'b1)            begin n_fail++; $display("FAIL miss_we: got %b want 1", icache_we); end
        n_tests++; if (icache_waddr !== 32'h10)       begin n_fail++; $display("FAIL miss_waddr: got %h want 10", icache_waddr); end
        n_tests++; if (icache_wdata !== 32'h0050_0093) begin n_fail++; $display("FAIL miss_wdata: got %h want 00500093", icache_wdata); end
        n_tests++; if (mem_req !== 1'b0)              begin n_fail++; $display("FAIL miss_req_drop: got %b want 0", mem_req); end
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_inst !== 32'h0050_0093)
            begin n_fail++; $display("FAIL miss_entry: valid=%b pc=%h inst=%h want 1 10 00500093", out_valid, out_pc, out_inst); end
        n_tests++; if (icache_addr !== 32'h14)        begin n_fail++; $display("FAIL miss_next_pc: got %h want 14", icache_addr); end
        step();
        n_tests++; if (icache_we !== 1'b0)            begin n_fail++; $display("FAIL miss_we_pulse: got %b want 0", icache_we); end
        n_tests++; if (out_pc !== 32'h14 || out_inst !== 32'hDEAD_0014)
            begin n_fail++; $display("FAIL miss_resume: pc=%h inst=%h want 14 dead0014", out_pc, out_inst); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 20; i++) step();
        n_tests++; if (icache_addr !== 32'h40) begin n_fail++; $display("FAIL full_pc: got %h want 40", icache_addr); end
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL full_head: valid=%b pc=%h want 1 0", out_valid, out_pc); end
        n_tests++; if (mem_req !== 1'b0)       begin n_fail++; $display("FAIL full_mem_req: got %b want 0", mem_req); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++; if (out_pc !== 32'h4 || icache_addr !== 32'h40)
            begin n_fail++; $display("FAIL full_pop_no_push: head=%h pc=%h want 4 40", out_pc, icache_addr); end
        step();
        n_tests++; if (icache_addr !== 32'h44) begin n_fail++; $display("FAIL full_refill: got %h want 44", icache_addr); end
        step();
        n_tests++; if (icache_addr !== 32'h44) begin n_fail++; $display("FAIL full_again: got %h want 44", icache_addr); end
        out_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k))
                begin n_fail++; $display("FAIL full_drain[%0d]: valid=%b pc=%h want 1 %h", k, out_valid, out_pc, 32'(4 * k)); end
            step();
        end
    endtask

    task automatic test_jump_discard();
        do_reset();
        miss_en = 1'b1; miss_addr = 32'h8;
        wait_mem_req("jump");
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL jump_pre_valid: got %b want 1", out_valid); end
        jump_flag = 1'b1; jump_pc = 32'h100;
        step();
        jump_flag = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || mem_req !== 1'b1 || icache_addr !== 32'h100)
            begin n_fail++; $display("FAIL jump_flush: valid=%b req=%b pc=%h want 0 1 100", out_valid, mem_req, icache_addr); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++; if (out_valid !== 1'b0 || mem_req !== 1'b1 || icache_addr !== 32'h100)
                begin n_fail++; $display("FAIL jump_discard[%0d]: valid=%b req=%b pc=%h want 0 1 100", i, out_valid, mem_req, icache_addr); end
        end
        mem_done = 1'b1; mem_inst = 32'h1234_5678;
        step();
        mem_done = 1'b0;
        n_tests++; if (icache_we !== 1'b1 || icache_waddr !== 32'h8 || icache_wdata !== 32'h1234_5678)
            begin n_fail++; $display("FAIL jump_fill: we=%b addr=%h data=%h want 1 8 12345678", icache_we, icache_waddr, icache_wdata); end
        n_tests++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || icache_addr !== 32'h100)
            begin n_fail++; $display("FAIL jump_no_push: valid=%b req=%b pc=%h want 0 0 100", out_valid, mem_req, icache_addr); end
        step();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || icache_addr !== 32'h104)
            begin n_fail++; $display("FAIL jump_restart: valid=%b head=%h pc=%h want 1 100 104", out_valid, out_pc, icache_addr); end
    endtask

    task automatic test_rdy_stall();
        do_reset();
        out_ready = 1'b1;
        repeat (3) step();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_inst !== 32'hDEAD_0008 || icache_addr !== 32'hC)
                begin n_fail++; $display("FAIL stall[%0d]: valid=%b head=%h inst=%h pc=%h want 1 8 dead0008 c", i, out_valid, out_pc, out_inst, icache_addr); end
        end
        rdy = 1'b1;
        step();
        n_tests++; if (out_pc !== 32'hC || icache_addr !== 32'h10) begin n_fail++; $display("FAIL stall_resume: head=%h pc=%h want c 10", out_pc, icache_addr); end
        step();
        n_tests++; if (out_pc !== 32'h10 || out_inst !== 32'hDEAD_0010) begin n_fail++; $display("FAIL stall_resume2: head=%h inst=%h want 10 dead0010", out_pc, out_inst); end
    endtask

    task automatic test_async_reset();
        do_reset();
        miss_en = 1'b1; miss_addr = 32'h4;
        wait_mem_req("arst");
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (mem_req !== 1'b0)      begin n_fail++; $display("FAIL arst_mem_req: got %b want 0", mem_req); end
        n_tests++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        n_tests++; if (icache_addr !== 32'h0) begin n_fail++; $display("FAIL arst_pc: got %h want 0", icache_addr); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_hit_stream();
        test_miss();
        test_full();
        test_jump_discard();
        test_rdy_stall();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
